// File: rtl/calc_display_pkg.sv
// Shared glyph patterns and glyph-select codes for the calculator's
// seven-segment output stage. Patterns are {g,f,e,d,c,b,a}, active-low.
package calc_display_pkg;

    localparam logic [6:0] G_0     = 7'b1000000;
    localparam logic [6:0] G_1     = 7'b1111001;
    localparam logic [6:0] G_2     = 7'b0100100;
    localparam logic [6:0] G_3     = 7'b0110000;
    localparam logic [6:0] G_4     = 7'b0011001;
    localparam logic [6:0] G_5     = 7'b0010010;
    localparam logic [6:0] G_6     = 7'b0000010;
    localparam logic [6:0] G_7     = 7'b1111000;
    localparam logic [6:0] G_8     = 7'b0000000;
    localparam logic [6:0] G_9     = 7'b0010000;
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    // Codes 0..9 coincide with the decimal digit value so a units digit casts directly.
    typedef enum logic [3:0] {
        GC_0     = 4'd0,
        GC_1     = 4'd1,
        GC_2     = 4'd2,
        GC_3     = 4'd3,
        GC_4     = 4'd4,
        GC_5     = 4'd5,
        GC_6     = 4'd6,
        GC_7     = 4'd7,
        GC_8     = 4'd8,
        GC_9     = 4'd9,
        GC_MINUS = 4'd10,
        GC_E     = 4'd11,
        GC_R     = 4'd12,
        GC_BLANK = 4'd15
    } glyph_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph-code to active-low seven-segment pattern lookup.
module seg7_encode
    import calc_display_pkg::*;
(
    input  glyph_t     code,
    output logic [6:0] seg
);

    always_comb begin
        seg = G_BLANK;
        case (code)
            GC_0:     seg = G_0;
            GC_1:     seg = G_1;
            GC_2:     seg = G_2;
            GC_3:     seg = G_3;
            GC_4:     seg = G_4;
            GC_5:     seg = G_5;
            GC_6:     seg = G_6;
            GC_7:     seg = G_7;
            GC_8:     seg = G_8;
            GC_9:     seg = G_9;
            GC_MINUS: seg = G_MINUS;
            GC_E:     seg = G_E;
            GC_R:     seg = G_R;
            default:  seg = G_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Latches a signed-magnitude calculator result and scans it onto a 4-digit
// common-anode display, showing a blinking "Err" on divide-by-zero.
module result_display
    import calc_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] result,
    input  logic       divbyzero,
    input  logic       zero,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] prescale;
    logic [1:0]    digit;
    logic [FW-1:0] frame_cnt;
    logic          blink_on;
    logic          valid;
    logic [4:0]    res_q;
    logic          err_q;
    logic          zq;

    logic          wrap;
    logic          frame_end;
    logic [3:0]    mag;
    logic          tens;
    logic [3:0]    units;
    glyph_t        code;
    logic [6:0]    seg_next;

    assign wrap      = (prescale == PS_LAST);
    assign frame_end = wrap && (digit == 2'd3);

    // A load restarts the blink phase but never disturbs the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale  <= '0;
            digit     <= 2'd0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            valid     <= 1'b0;
            res_q     <= 5'd0;
            err_q     <= 1'b0;
            zq        <= 1'b0;
        end else begin
            prescale <= wrap ? '0 : prescale + 1'b1;
            if (wrap) begin
                digit <= digit + 2'd1;
            end
            if (load) begin
                res_q     <= result;
                err_q     <= divbyzero;
                zq        <= zero | (result[3:0] == 4'd0);
                valid     <= 1'b1;
                blink_on  <= 1'b1;
                frame_cnt <= '0;
            end else if (frame_end) begin
                if (frame_cnt == FR_LAST) begin
                    blink_on  <= ~blink_on;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mag   = res_q[3:0];
        tens  = (mag >= 4'd10);
        units = tens ? (mag - 4'd10) : mag;
        code  = GC_BLANK;
        if (err_q) begin
            if (blink_on) begin
                case (digit)
                    2'd2:      code = GC_E;
                    2'd1, 2'd0: code = GC_R;
                    default:   code = GC_BLANK;
                endcase
            end
        end else begin
            case (digit)
                2'd0:    code = glyph_t'(units);
                2'd1:    code = tens ? GC_1 : GC_BLANK;
                2'd3:    code = (res_q[4] && !zq) ? GC_MINUS : GC_BLANK;
                default: code = GC_BLANK;
            endcase
        end
    end

    seg7_encode u_encode (
        .code (code),
        .seg  (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst || !valid) begin
            seg <= G_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= seg_next;
            an  <= ~(4'b0001 << digit);
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: expected display words are pushed per
// clock from an arithmetic model and popped by a separate negedge monitor.
module tb_result_display;

    localparam int D  = 4;
    localparam int BF = 2;

    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GM = 7'b0111111;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GR = 7'b0101111;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [4:0] result = 5'd0;
    logic       divbyzero = 1'b0;
    logic       zero = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    bit       m_valid = 1'b0;
    logic [4:0] m_res = 5'd0;
    bit       m_err = 1'b0;
    bit       m_zero = 1'b0;
    int       m_k = 0;
    int       m_kl = 0;

    always #5 clk = ~clk;

    result_display #(
        .SCAN_DIV     (D),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .result    (result),
        .divbyzero (divbyzero),
        .zero      (zero),
        .seg       (seg),
        .an        (an)
    );

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return GB;
        endcase
    endfunction

    // Display word implied by m_k clock edges since reset and the last capture.
    function automatic exp_t model_out();
        exp_t e;
        int   slot;
        int   mag;
        int   frames;
        bit   lit;
        e.an  = 4'hF;
        e.seg = GB;
        if (!m_valid) return e;
        slot = (m_k / D) % 4;
        e.an = ~(4'b0001 << slot);
        if (m_err) begin
            frames = (m_k / (4 * D)) - (m_kl / (4 * D));
            lit    = ((frames / BF) % 2) == 0;
            if (lit) begin
                if (slot == 2) e.seg = GE;
                else if (slot == 1 || slot == 0) e.seg = GR;
            end
        end else begin
            mag = int'(m_res[3:0]);
            if (slot == 0) e.seg = digit_glyph(mag % 10);
            else if (slot == 1) e.seg = (mag >= 10) ? digit_glyph(mag / 10) : GB;
            else if (slot == 3) e.seg = (m_res[4] && !m_zero) ? GM : GB;
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input bit l, input logic [4:0] res,
                                 input bit dbz, input bit z);
        exp_t e;
        rst       = r;
        load      = l;
        result    = res;
        divbyzero = dbz;
        zero      = z;
        @(posedge clk);
        if (r) begin
            e.an  = 4'hF;
            e.seg = GB;
        end else begin
            e = model_out();
        end
        exp_q.push_back(e);
        if (r) begin
            m_k     = 0;
            m_kl    = 0;
            m_valid = 1'b0;
            m_res   = 5'd0;
            m_err   = 1'b0;
            m_zero  = 1'b0;
        end else begin
            m_k = m_k + 1;
            if (l) begin
                m_valid = 1'b1;
                m_res   = res;
                m_err   = dbz;
                m_zero  = z || (res[3:0] == 4'd0);
                m_kl    = m_k;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (an !== e.an || seg !== e.seg) begin
            mismatched++;
            $display("[TB] FAIL display t=%0t got an=%b seg=%b, expected an=%b seg=%b",
                     $time, an, seg, e.an, e.seg);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        repeat (3) applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(40);
        applyStimulus(1'b0, 1'b1, 5'b1_0011, 1'b0, 1'b0);
        idle(40);
        applyStimulus(1'b0, 1'b1, 5'b0_1100, 1'b0, 1'b0);
        idle(40);
        applyStimulus(1'b0, 1'b1, 5'b1_0000, 1'b0, 1'b1);
        idle(40);
        applyStimulus(1'b0, 1'b1, 5'b0_0111, 1'b1, 1'b0);
        idle(150);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 5'b0_0101, 1'b0, 1'b0);
        idle(40);
        applyStimulus(1'b1, 1'b1, 5'b1_1111, 1'b0, 1'b0);
        idle(10);
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 59) == 0,
                          5'($urandom),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0);
        end
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream output stage of the calculator datapath.
- Consumes the 5-bit signed-magnitude result and the divbyzero/zero flags produced by the arithmetic units (remainder, quotient, etc.).
- Latches the result on a load strobe and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Renders sign, tens and units digits, or a blinking "Err" on divide-by-zero.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Must be >= 2.
- BLINK_FRAMES, 64: full 4-digit scan frames per blink half-period in error mode. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture strobe; samples result/divbyzero/zero on the clk edge where it is high.
- result  in  5  signed magnitude. [4] is the sign (1 = negative); [3:0] is the magnitude, 0..15.
- divbyzero  in  1  error flag from the arithmetic stage.
- zero  in  1  result-is-zero flag from the arithmetic stage.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low. an[0] = units (rightmost), an[3] = sign (leftmost).

Behaviour:
- Only one clock (clk). All state updates on the rising edge of clk. rst is synchronous, active-high and overrides every other input.
- Reset values:
  - seg = 7'h7F, an = 4'hF.
  - Prescaler = 0, digit index = 0, frame counter = 0, blink_on = 1.
  - valid = 0; captured registers = 0.
- Capture on the load edge:
  - res_q <= result; err_q <= divbyzero; zq <= zero | (result[3:0] == 0); valid <= 1.
  - blink_on <= 1 and frame counter <= 0.
  - Load has no effect on the prescaler or the digit index.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and then wraps.
  - On wrap, the digit index advances 0 -> 1 -> 2 -> 3 -> 0.
  - Wrap from 3 to 0 ends a frame.
- Blink:
  - At end of frame, if frame counter == BLINK_FRAMES-1, toggle blink_on and clear the counter; otherwise increment the counter.
  - blink_on matters only when err_q = 1.
- Outputs are registered: seg/an reflect the state of the previous cycle (1-cycle latency).
- While valid = 0: an = 4'hF, seg = 7'h7F.
- While valid = 1: an = ~(4'b0001 << digit index).
- Digit content in normal mode (err_q = 0):
  - Digit 0: units = magnitude mod 10.
  - Digit 1: '1' if magnitude >= 10, else blank (leading-zero suppression).
  - Digit 2: blank.
  - Digit 3: '-' if sign = 1 and zq = 0, else blank. Negative zero displays as "0" with no sign.
- Digit content in error mode (err_q = 1): digit 3 blank, digit 2 'E', digit 1 'r', digit 0 'r'. When blink_on = 0, all digits are blank but an keeps scanning.
- Magnitude -> digits: tens = (mag >= 10), units = mag - 10·tens. This is combinational and needs no divider.
- Simultaneous events:
  - load on the same edge as a prescaler wrap: the digit index still advances, and the new value is shown starting with that new slot.
  - load while rst: rst wins.
- Reset mid-scan: on the next edge all state returns to reset values; the display is dark until the next load.

Decomposition:
- Package calc_display_pkg contains the glyph constants (active-low):
  - G_0 = 7'b1000000, G_1 = 7'b1111001, G_2 = 7'b0100100, G_3 = 7'b0110000
  - G_4 = 7'b0011001, G_5 = 7'b0010010, G_6 = 7'b0000010, G_7 = 7'b1111000
  - G_8 = 7'b0000000, G_9 = 7'b0010000
  - G_MINUS = 7'b0111111, G_E = 7'b0000110, G_R = 7'b0101111, G_BLANK = 7'b1111111
  - Glyph-select codes for the encoder.
- Sub-module seg7_encode: combinational, 4-bit glyph code -> 7-bit active-low pattern.
- Prescaler, scan, blink and capture logic stay in result_display.

Test Plan (SCAN_DIV = 4, BLINK_FRAMES = 2):
- rst high for 3 cycles, then idle 40 cycles with no load -> an = 4'hF, seg = 7'h7F throughout.
- load with result = 5'b1_0011, zero = 0 -> per slot:
  - an = 4'b1110 / seg = G_3
  - an = 4'b1101 / G_BLANK
  - an = 4'b1011 / G_BLANK
  - an = 4'b0111 / G_MINUS
  - Each slot lasts 4 cycles and the pattern repeats.
- load with result = 5'b0_1100 -> units slot G_2, tens slot G_1, sign slot G_BLANK.
- load with result = 5'b1_0000, zero = 1 -> units slot G_0, all other slots G_BLANK (no '-').
- load with divbyzero = 1 -> first 32 cycles (2 frames): slots 2/1/0 show G_E/G_R/G_R. Next 32 cycles: all slots G_BLANK while an keeps scanning. Then the on/off pattern repeats.
- Assert rst mid-frame during error display -> next cycle an = 4'hF, seg = 7'h7F. A subsequent load of 5'b0_0101 shows G_5 in the units slot with blink_on = 1.
